// File: rtl/uart_loader.sv
// -----------------------------------------------------------------------------
// uart_loader
//
// Serial boot loader. It receives an 8N1 UART byte stream and assembles
// little-endian 32-bit words. Each word is presented with its byte address
// on the CPU boot-load port. uart_over rises once the whole image is in.
//
// Image format: 4-byte little-endian word count N, then N words of 4 bytes
// each (byte 0 -> bits [7:0]). With LOADER_CHECKSUM_EN defined, one trailing
// byte follows: the XOR of all payload bytes (header excluded).
//
// Optional feature macro: LOADER_CHECKSUM_EN
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 4)
//   MAX_WORDS     largest accepted image length in 32-bit words
//
// Ports:
//   clk           system clock (only clock)
//   reset         asynchronous active-low reset
//   uart_rx       serial line, idles high, asynchronous to clk
//   uart_data     last assembled word (held between writes)
//   uart_address  byte address of uart_data (held between writes)
//   uart_write    one-cycle pulse when uart_data/uart_address update
//   uart_over     image complete, sticky until reset
//   load_error    sticky framing/length/checksum error flag
// -----------------------------------------------------------------------------
module uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_WORDS    = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic [31:0] uart_data,
  output logic [31:0] uart_address,
  output logic        uart_write,
  output logic        uart_over,
  output logic        load_error
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {LD_LEN, LD_WORDS, LD_CSUM, LD_DONE} ld_state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizer. Both flops reset to the idle level so that reset
  // release does not look like a start bit.
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q, rx_prev_q;
  logic rx_s, rx_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= uart_rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  assign rx_s    = sync2_q;
  assign rx_fall = rx_prev_q & ~rx_s;

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_fall) rx_state_d = RX_START;
      end
      RX_START: begin
        // Half a bit after the edge we are mid start bit; high means glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d      = '0;
          bit_d      = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
          else               bit_d      = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          rx_state_d   = RX_IDLE;
          byte_valid_d = rx_s;
          frame_err_d  = ~rx_s;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  ld_state_e   ld_state_q, ld_state_d;
  logic [1:0]  phase_q, phase_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] nwords_q, nwords_d;
  logic [31:0] widx_q, widx_d;
  logic [31:0] data_q, data_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic        over_q, over_d;
  logic        err_q, err_d;
  logic [31:0] word_next;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  // Bytes shift in from the top so byte 0 ends up in bits [7:0].
  assign word_next = {shift_q, asm_q[31:8]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_state_q <= LD_LEN;
      phase_q    <= '0;
      asm_q      <= '0;
      nwords_q   <= '0;
      widx_q     <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      over_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      ld_state_q <= ld_state_d;
      phase_q    <= phase_d;
      asm_q      <= asm_d;
      nwords_q   <= nwords_d;
      widx_q     <= widx_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      over_q     <= over_d;
      err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    ld_state_d = ld_state_q;
    phase_d    = phase_q;
    asm_d      = asm_q;
    nwords_d   = nwords_q;
    widx_d     = widx_q;
    data_d     = data_q;
    addr_d     = addr_q;
    write_d    = 1'b0;
    err_d      = err_q;
    // Registered from the state so uart_over trails the last write by a cycle.
    over_d     = (ld_state_q == LD_DONE);
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (frame_err_q && (ld_state_q != LD_DONE)) begin
      // Abort the image; the output registers keep their last word.
      err_d      = 1'b1;
      ld_state_d = LD_LEN;
      phase_d    = '0;
      widx_d     = '0;
    end else if (byte_valid_q) begin
      unique case (ld_state_q)
        LD_LEN: begin
          asm_d   = word_next;
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            if (word_next == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              csum_d     = 8'h00;
              ld_state_d = LD_CSUM;
`else
              ld_state_d = LD_DONE;
`endif
            end else if (word_next > 32'(MAX_WORDS)) begin
              err_d = 1'b1;
            end else begin
              nwords_d   = word_next;
              widx_d     = '0;
              ld_state_d = LD_WORDS;
`ifdef LOADER_CHECKSUM_EN
              csum_d     = 8'h00;
`endif
            end
          end
        end
        LD_WORDS: begin
          asm_d   = word_next;
          phase_d = phase_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ shift_q;
`endif
          if (phase_q == 2'd3) begin
            write_d = 1'b1;
            data_d  = word_next;
            addr_d  = {widx_q[29:0], 2'b00};
            widx_d  = widx_q + 32'd1;
            if (widx_q == nwords_q - 32'd1) begin
`ifdef LOADER_CHECKSUM_EN
              ld_state_d = LD_CSUM;
`else
              ld_state_d = LD_DONE;
`endif
            end
          end
        end
        LD_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
          if (shift_q == csum_q) begin
            ld_state_d = LD_DONE;
          end else begin
            err_d      = 1'b1;
            ld_state_d = LD_LEN;
            phase_d    = '0;
            widx_d     = '0;
            csum_d     = 8'h00;
          end
`endif
        end
        default: ;  // LD_DONE: ignore everything
      endcase
    end
  end

  assign uart_data    = data_q;
  assign uart_address = addr_q;
  assign uart_write   = write_q;
  assign uart_over    = over_q;
  assign load_error   = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_loader: self-checking bench for uart_loader. A byte-level image
// model (queue of received bytes, decoded with plain arithmetic) predicts
// the write sequence, completion and error flags; a per-cycle compare
// process checks the DUT outputs against it.
// -----------------------------------------------------------------------------
module tb_uart_loader;

  localparam int CPB  = 16;
  localparam int MAXW = 16384;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        uart_rx = 1'b1;
  logic [31:0] uart_data, uart_address;
  logic        uart_write, uart_over, load_error;

  uart_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rx      (uart_rx),
    .uart_data    (uart_data),
    .uart_address (uart_address),
    .uart_write   (uart_write),
    .uart_over    (uart_over),
    .load_error   (load_error)
  );

  always #5 clk = ~clk;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  // model state
  logic [7:0]  rxq[$];
  logic [31:0] exp_addr_q[$], exp_data_q[$];
  logic [31:0] log_addr[$], log_data[$];
  int          m_n = 0;
  bit          m_done = 0, m_err = 0, m_done_by_word = 0;
  logic [31:0] held_data = '0, held_addr = '0;
  logic        over_prev = 1'b0, write_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
  endtask

  // Image-level interpretation of one received byte.
  task automatic model_byte(input logic [7:0] b, input bit ok);
    int L;
    logic [31:0] n;
    logic [7:0] x;
    if (m_done) return;
    if (!ok) begin
      m_err = 1;
      rxq.delete();
      return;
    end
    rxq.push_back(b);
    L = rxq.size();
    if (L < 4) return;
    if (L == 4) begin
      n = {rxq[3], rxq[2], rxq[1], rxq[0]};
      if (n > 32'(MAXW)) begin
        m_err = 1;
        rxq.delete();
      end else begin
        m_n = int'(n);
        if (m_n == 0 && !CSUM_EN) begin
          m_done = 1;
          m_done_by_word = 0;
        end
      end
      return;
    end
    if (L <= 4 + 4 * m_n) begin
      if ((L - 4) % 4 == 0) begin
        exp_addr_q.push_back(32'(4 * ((L - 4) / 4 - 1)));
        exp_data_q.push_back({rxq[L-1], rxq[L-2], rxq[L-3], rxq[L-4]});
        if (L == 4 + 4 * m_n && !CSUM_EN) begin
          m_done = 1;
          m_done_by_word = 1;
        end
      end
      return;
    end
    x = 8'h00;
    for (int i = 4; i < L - 1; i++) x ^= rxq[i];
    if (x == b) m_done = 1;
    else begin
      m_err = 1;
      rxq.delete();
    end
  endtask

  // Per-cycle compare process.
  always @(negedge clk) begin
    if (!reset) begin
      check("rst_data", uart_data, 32'd0);
      check("rst_addr", uart_address, 32'd0);
      check("rst_write", 32'(uart_write), 32'd0);
      check("rst_over", 32'(uart_over), 32'd0);
      check("rst_err", 32'(load_error), 32'd0);
    end else begin
      if (uart_write) begin
        total_cnt++;
        if (exp_addr_q.size() == 0) begin
          $display("FAIL unexpected_write: actual addr %h data %h, required no write", uart_address, uart_data);
        end else begin
          pass_cnt++;
          held_addr = exp_addr_q.pop_front();
          held_data = exp_data_q.pop_front();
          check("write_addr", uart_address, held_addr);
          check("write_data", uart_data, held_data);
        end
        log_addr.push_back(uart_address);
        log_data.push_back(uart_data);
        $display("write addr=%h data=%h", uart_address, uart_data);
      end else begin
        check("hold_addr", uart_address, held_addr);
        check("hold_data", uart_data, held_data);
      end
      if (uart_over) check("over_early", 32'(m_done), 32'd1);
      if (load_error) check("error_spurious", 32'(m_err), 32'd1);
      if (uart_over && !over_prev && m_done_by_word) check("over_timing", 32'(write_prev), 32'd1);
    end
    over_prev  <= uart_over;
    write_prev <= uart_write;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset   = 1'b0;
    uart_rx = 1'b1;
    rxq.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    log_addr.delete();
    log_data.delete();
    m_n = 0; m_done = 0; m_err = 0; m_done_by_word = 0;
    held_addr = '0; held_data = '0;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    model_byte(b, stop_ok);
    uart_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    if (!stop_ok) begin
      uart_rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
    end
  endtask

  // Sends the image; bad_frame_idx >= 0 sends that byte with a 0 stop bit.
  task automatic send_image(input logic [7:0] img[$], input bit bad_csum, input int bad_frame_idx);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < img.size(); i++) begin
      if (i == bad_frame_idx) begin
        send_byte(img[i], 1'b0);
        return;
      end
      send_byte(img[i], 1'b1);
      if (i >= 4) x ^= img[i];
    end
    if (CSUM_EN) send_byte(bad_csum ? (x ^ 8'h01) : x, 1'b1);
    $display("image sent: %0d bytes", img.size());
  endtask

  task automatic finish_check(input string tag);
    repeat (3 * CPB) @(negedge clk);
    check({tag, "_over"}, 32'(uart_over), 32'(m_done));
    check({tag, "_err"}, 32'(load_error), 32'(m_err));
    check({tag, "_pending"}, 32'(exp_addr_q.size()), 32'd0);
  endtask

  logic [7:0] img1[$] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                          8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] hdr0[$] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] hdrbig[$] = '{8'h01, 8'h40, 8'h00, 8'h00};

  initial begin
    logic [7:0] img[$];
    logic [7:0] part[$];
    int nw;

    // 1: two-word image, then trailing bytes must be ignored
    do_reset();
    check("reset_over", 32'(uart_over), 32'd0);
    send_image(img1, 1'b0, -1);
    finish_check("img1");
    check("img1_nwrites", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      check("img1_a0", log_addr[0], 32'h0);
      check("img1_d0", log_data[0], 32'h00000013);
      check("img1_a1", log_addr[1], 32'h4);
      check("img1_d1", log_data[1], 32'hDEADBEEF);
    end
    check("img1_over_lit", 32'(uart_over), 32'd1);
    check("img1_err_lit", 32'(load_error), 32'd0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
    finish_check("after_done");
    check("after_done_data", uart_data, 32'hDEADBEEF);

`ifdef LOADER_CHECKSUM_EN
    // 2: bad checksum, then correct retransmission
    do_reset();
    send_image(img1, 1'b1, -1);
    finish_check("badcsum");
    check("badcsum_err_lit", 32'(load_error), 32'd1);
    check("badcsum_over_lit", 32'(uart_over), 32'd0);
    send_image(img1, 1'b0, -1);
    finish_check("resend");
    check("resend_over_lit", 32'(uart_over), 32'd1);
`endif

    // 3: idle glitch, then N = 0 header
    do_reset();
    @(negedge clk); uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_err", 32'(load_error), 32'd0);
    send_image(hdr0, 1'b0, -1);
    finish_check("n0");
    check("n0_nwrites", 32'(log_addr.size()), 32'd0);
    check("n0_over_lit", 32'(uart_over), 32'd1);

    // 4: framing error on the 6th byte, then full resend
    do_reset();
    send_image(img1, 1'b0, 5);
    finish_check("frame");
    check("frame_err_lit", 32'(load_error), 32'd1);
    send_image(img1, 1'b0, -1);
    finish_check("frame_resend");
    check("frame_nwrites", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() > 0) check("frame_a0", log_addr[0], 32'h0);
    check("frame_over_lit", 32'(uart_over), 32'd1);

    // 5: oversize header
    do_reset();
    send_image(hdrbig, 1'b0, -1);
    finish_check("big");
    check("big_err_lit", 32'(load_error), 32'd1);
    check("big_over_lit", 32'(uart_over), 32'd0);
    check("big_nwrites", 32'(log_addr.size()), 32'd0);

    // 6: reset in the middle of word 1
    do_reset();
    part = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < part.size(); i++) send_byte(part[i], 1'b1);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      uart_rx = 1'(i);
      repeat (CPB) @(negedge clk);
    end
    do_reset();
    check("midrst_data", uart_data, 32'd0);
    check("midrst_addr", uart_address, 32'd0);
    check("midrst_err", 32'(load_error), 32'd0);
    send_image(img1, 1'b0, -1);
    finish_check("midrst_reload");
    if (log_addr.size() > 0) check("midrst_a0", log_addr[0], 32'h0);

    // 7: random images
    for (int t = 0; t < 3; t++) begin
      do_reset();
      nw = int'($urandom_range(1, 5));
      img.delete();
      img.push_back(8'(nw));
      img.push_back(8'h00);
      img.push_back(8'h00);
      img.push_back(8'h00);
      for (int i = 0; i < 4 * nw; i++) img.push_back(8'($urandom));
      send_image(img, 1'b0, -1);
      finish_check("rand");
      check("rand_nwrites", 32'(log_addr.size()), 32'(nw));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1);
  end

endmodule
